stream_mux: RTL and testbench



---
 rtl/stream_mux_if.sv | 60 ++++++
 rtl/stream_mux.sv | 124 ++++++++++++
 tb/tb_stream_mux.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_if.sv
// -----------------------------------------------------------------------------
// stream_mux_if
//   Bundles the handshake and data signals of stream_mux: NUM_IN producer
//   channels and one consumer channel.
//
//   Producer side (per channel i):
//     in_data[i*WIDTH +: WIDTH]  channel word
//     in_valid[i]                channel i offers a word
//     in_ready[i]                channel i word is taken this cycle
//   Control:
//     mode                       0 = fixed select, 1 = round-robin
//     sel                        channel index used in fixed mode
//   Consumer side:
//     out_result                 registered output word
//     out_valid                  out_result holds a word
//     out_ready                  consumer takes out_result this cycle
//     out_sel                    channel the held word came from
//
//   master : the environment (producers, consumer, control)
//   slave  : the multiplexer itself
// -----------------------------------------------------------------------------
interface stream_mux_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_result;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_sel;

  modport master (
    output in_data,
    output in_valid,
    output mode,
    output sel,
    output out_ready,
    input  in_ready,
    input  out_result,
    input  out_valid,
    input  out_sel
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  mode,
    input  sel,
    input  out_ready,
    output in_ready,
    output out_result,
    output out_valid,
    output out_sel
  );
endinterface

// File: rtl/stream_mux.sv
// -----------------------------------------------------------------------------
// stream_mux
//   N:1 registered stream multiplexer with valid/ready on every channel.
//   One input channel is chosen either by an explicit index (mode 0) or by a
//   round-robin arbiter (mode 1); the chosen word is captured in a single
//   output register together with the index of the channel it came from.
//
//   Ports:
//     clk    rising-edge clock for all state
//     reset  synchronous, active-high; empties the output register and
//            restarts the round-robin pointer at channel 0
//     bus    stream_mux_if.slave: in_data/in_valid/in_ready per channel,
//            mode/sel control, out_result/out_valid/out_ready/out_sel
//
//   SEL_W must equal ceil(log2(NUM_IN)); NUM_IN is 2..16.
// -----------------------------------------------------------------------------
module stream_mux #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic         clk,
  input  logic         reset,
  stream_mux_if.slave  bus
);

  // Output register and arbiter state
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_result;
  logic [SEL_W-1:0]    r_out_sel;
  logic [SEL_W-1:0]    r_ptr;

  // Combinational grant path
  logic                w_load;
  logic [NUM_IN-1:0]   w_grant_fix;
  logic [NUM_IN-1:0]   w_rr_mask;
  logic [NUM_IN-1:0]   w_rr_hi;
  logic [NUM_IN-1:0]   w_rr_hi_first;
  logic [NUM_IN-1:0]   w_rr_all_first;
  logic [NUM_IN-1:0]   w_grant_rr;
  logic [NUM_IN-1:0]   w_grant;
  logic                w_any_grant;
  logic [SEL_W-1:0]    w_grant_idx;
  logic [WIDTH-1:0]    w_grant_data;
  logic [SEL_W-1:0]    w_ptr_next;

  // The register can take a new word when it is empty or being drained now.
  assign w_load = ~r_out_valid | bus.out_ready;

  // Fixed mode: only the addressed channel can be granted. An index at or
  // beyond NUM_IN matches no channel and therefore grants nothing.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_fix
      assign w_grant_fix[gi] = bus.in_valid[gi] & (bus.sel == SEL_W'(gi));
    end
  endgenerate

  // Round-robin: split the request vector at the pointer. Requests at or
  // above the pointer take precedence (lowest index first); if there are
  // none, the search wraps to the lowest requesting channel overall. This
  // is equivalent to scanning ptr, ptr+1, ... modulo NUM_IN.
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_mask
      assign w_rr_mask[gi] = (SEL_W'(gi) >= r_ptr);
    end
  endgenerate

  assign w_rr_hi        = bus.in_valid & w_rr_mask;
  // x & -x isolates the lowest set bit.
  assign w_rr_hi_first  = w_rr_hi & (~w_rr_hi + NUM_IN'(1));
  assign w_rr_all_first = bus.in_valid & (~bus.in_valid + NUM_IN'(1));
  assign w_grant_rr     = (|w_rr_hi) ? w_rr_hi_first : w_rr_all_first;

  // The mode input applies to the grant in the same cycle it changes.
  assign w_grant     = bus.mode ? w_grant_rr : w_grant_fix;
  assign w_any_grant = |w_grant;

  // One-hot grant to index and data. AND-OR form keeps the data path a
  // balanced mux; the grant is never more than one-hot.
  always_comb begin
    w_grant_idx  = '0;
    w_grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_grant_idx  = w_grant_idx  | ({SEL_W{w_grant[i]}} & SEL_W'(i));
      w_grant_data = w_grant_data | ({WIDTH{w_grant[i]}} & bus.in_data[i*WIDTH +: WIDTH]);
    end
  end

  // Explicit wrap so non-power-of-two channel counts return to 0.
  assign w_ptr_next = (w_grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : w_grant_idx + 1'b1;

  // Nothing is accepted while reset is asserted, so no producer believes a
  // word was taken that the reset is about to discard.
  assign bus.in_ready = (w_load & ~reset) ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_sel    <= '0;
      r_ptr        <= '0;
    end else if (w_load) begin
      if (w_any_grant) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_grant_data;
        r_out_sel    <= w_grant_idx;
        // Only arbitrated transfers advance the fairness pointer.
        if (bus.mode) begin
          r_ptr <= w_ptr_next;
        end
      end else begin
        // Drained with nothing to replace it: empty, but keep the last
        // word and index visible.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_sel    = r_out_sel;

endmodule

// File: tb/tb_stream_mux.sv
// -----------------------------------------------------------------------------
// tb_stream_mux
//   Self-checking bench for stream_mux. The 4-channel instance is tracked by
//   a behavioural model (grant found by a modular scan from the pointer);
//   5- and 3-channel instances cover out-of-range select and pointer wrap
//   for non-power-of-two channel counts.
// -----------------------------------------------------------------------------
module tb_stream_mux;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  stream_mux_if #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) bus4 ();
  stream_mux_if #(.WIDTH(16), .NUM_IN(5), .SEL_W(3)) bus5 ();
  stream_mux_if #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) bus3 ();

  stream_mux #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
  stream_mux #(.WIDTH(16), .NUM_IN(5), .SEL_W(3)) u_dut5 (.clk(clk), .reset(reset), .bus(bus5));
  stream_mux #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // Reference state for the 4-channel instance
  int          m_valid;
  logic [15:0] m_result;
  int          m_sel;
  int          m_ptr;

  // Which channel should win: fixed index, or first valid scanning from the
  // pointer modulo n. Returns -1 when nothing is granted.
  function automatic int model_grant(int n, int ptr, logic [15:0] valid, bit mode, int sel);
    if (!mode) begin
      if (sel < n && valid[sel]) return sel;
      return -1;
    end
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (ptr + k) % n;
      if (valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_valid  = 0;
    m_result = 16'h0000;
    m_sel    = 0;
    m_ptr    = 0;
  endtask

  task automatic do_reset(int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // One clock of the 4-channel instance. Inputs are set by the caller just
  // after a rising edge; the ready vector is checked before the next edge
  // and the registered outputs just after it.
  task automatic step4(string tag);
    int         g;
    bit         load;
    logic [3:0] exp_rdy;
    #1;
    g       = model_grant(4, m_ptr, {12'b0, bus4.in_valid}, bus4.mode, int'(bus4.sel));
    load    = (m_valid == 0) || bus4.out_ready;
    exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
    checks++;
    if (bus4.in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL %s in_ready: got %b expected %b", tag, bus4.in_ready, exp_rdy);
    end
    if (load) begin
      if (g >= 0) begin
        m_valid  = 1;
        m_result = bus4.in_data[g*16 +: 16];
        m_sel    = g;
        if (bus4.mode) m_ptr = (g + 1) % 4;
      end else begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus4.out_valid !== 1'(m_valid)) begin
      errors++;
      $display("FAIL %s out_valid: got %b expected %0d", tag, bus4.out_valid, m_valid);
    end
    checks++;
    if (bus4.out_result !== m_result) begin
      errors++;
      $display("FAIL %s out_result: got %h expected %h", tag, bus4.out_result, m_result);
    end
    checks++;
    if (bus4.out_sel !== 2'(m_sel)) begin
      errors++;
      $display("FAIL %s out_sel: got %0d expected %0d", tag, bus4.out_sel, m_sel);
    end
    $display("txn %s mode=%0d sel=%0d vld=%b ordy=%0d -> rdy=%b out_v=%0d res=%h osel=%0d",
             tag, bus4.mode, bus4.sel, bus4.in_valid, bus4.out_ready, exp_rdy,
             bus4.out_valid, bus4.out_result, bus4.out_sel);
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus4.mode      = 1'b1;
    bus4.sel       = 2'd0;
    bus4.in_valid  = 4'b1111;
    bus4.in_data   = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    bus4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus4.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_c1 in_ready: got %b expected 0000", bus4.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus4.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_c2 in_ready: got %b expected 0000", bus4.in_ready);
    end
    checks++;
    if (bus4.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset out_valid: got %b expected 0", bus4.out_valid);
    end
    checks++;
    if (bus4.out_result !== 16'h0000) begin
      errors++;
      $display("FAIL reset out_result: got %h expected 0000", bus4.out_result);
    end
    checks++;
    if (bus4.out_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset out_sel: got %0d expected 0", bus4.out_sel);
    end
    $display("txn reset held 2 cycles out_valid=%0d", bus4.out_valid);
    reset = 1'b0;
    model_clear();
    step4("reset_first_rr");
    checks++;
    if (bus4.out_sel !== 2'd0 || bus4.out_result !== 16'hD000) begin
      errors++;
      $display("FAIL reset_first_rr grant: got ch%0d %h expected ch0 d000", bus4.out_sel, bus4.out_result);
    end
  endtask

  task automatic test_fixed();
    bus4.mode      = 1'b0;
    bus4.sel       = 2'd2;
    bus4.in_valid  = 4'b1111;
    bus4.in_data   = {16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
    bus4.out_ready = 1'b1;
    step4("fixed_sel2");
    checks++;
    if (bus4.out_result !== 16'hBEEF || bus4.out_sel !== 2'd2) begin
      errors++;
      $display("FAIL fixed_sel2 word: got %h ch%0d expected beef ch2", bus4.out_result, bus4.out_sel);
    end
    // Selected channel idle: output empties, last word stays visible
    bus4.sel      = 2'd1;
    bus4.in_valid = 4'b1101;
    step4("fixed_idle");
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.out_result !== 16'hBEEF) begin
      errors++;
      $display("FAIL fixed_idle: got v=%b %h expected v=0 beef", bus4.out_valid, bus4.out_result);
    end
  endtask

  task automatic test_rr_fair();
    int seq_a[6] = '{0, 1, 2, 3, 0, 1};
    int seq_b[4] = '{1, 3, 1, 3};
    do_reset(1);
    bus4.mode      = 1'b1;
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      bus4.in_data = {$urandom, $urandom};
      step4("rr_all");
      checks++;
      if (bus4.out_sel !== 2'(seq_a[i])) begin
        errors++;
        $display("FAIL rr_all step %0d: got ch%0d expected ch%0d", i, bus4.out_sel, seq_a[i]);
      end
    end
    do_reset(1);
    bus4.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      bus4.in_data = {$urandom, $urandom};
      step4("rr_odd");
      checks++;
      if (bus4.out_sel !== 2'(seq_b[i])) begin
        errors++;
        $display("FAIL rr_odd step %0d: got ch%0d expected ch%0d", i, bus4.out_sel, seq_b[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] word;
    bus4.mode      = 1'b0;
    bus4.sel       = 2'd0;
    bus4.in_valid  = 4'b0001;
    bus4.in_data   = {48'h0, 16'h1234};
    bus4.out_ready = 1'b1;
    step4("bp_fill");
    bus4.in_data   = {48'h0, 16'h5678};
    bus4.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step4("bp_stall");
      checks++;
      if (bus4.out_result !== 16'h1234 || bus4.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall %0d: got v=%b %h expected v=1 1234", i, bus4.out_valid, bus4.out_result);
      end
    end
    bus4.out_ready = 1'b1;
    step4("bp_release");
    checks++;
    if (bus4.out_result !== 16'h5678 || bus4.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v=%b %h expected v=1 5678", bus4.out_valid, bus4.out_result);
    end
    // Sustained flow: a new word every cycle, never a bubble
    for (int i = 0; i < 4; i++) begin
      word         = 16'($urandom);
      bus4.in_data = {48'h0, word};
      step4("b2b");
      checks++;
      if (bus4.out_result !== word || bus4.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b %0d: got v=%b %h expected v=1 %h", i, bus4.out_valid, bus4.out_result, word);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    bus4.mode      = 1'b1;
    bus4.in_valid  = 4'b0100;
    bus4.in_data   = {16'h0, 16'hAAAA, 32'h0};
    bus4.out_ready = 1'b1;
    step4("rmid_fill");
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b0;
    step4("rmid_stall");
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_reset: got v=%b rdy=%b expected v=0 rdy=0000", bus4.out_valid, bus4.in_ready);
    end
    $display("txn rmid reset edge out_valid=%0d", bus4.out_valid);
    reset = 1'b0;
    model_clear();
    bus4.out_ready = 1'b1;
    bus4.in_data   = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
    step4("rmid_after");
    checks++;
    if (bus4.out_sel !== 2'd0 || bus4.out_result !== 16'hC000) begin
      errors++;
      $display("FAIL rmid_after: got ch%0d %h expected ch0 c000", bus4.out_sel, bus4.out_result);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      bus4.in_valid  = 4'($urandom);
      bus4.mode      = 1'($urandom);
      bus4.sel       = 2'($urandom);
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      bus4.in_data   = {$urandom, $urandom};
      step4("rand");
    end
  endtask

  task automatic test_sel_oob();
    do_reset(1);
    bus5.mode      = 1'b0;
    bus5.sel       = 3'd4;
    bus5.in_valid  = 5'b11111;
    bus5.in_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0000};
    bus5.out_ready = 1'b1;
    #1;
    checks++;
    if (bus5.in_ready !== 5'b10000) begin
      errors++;
      $display("FAIL n5_sel4 in_ready: got %b expected 10000", bus5.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus5.out_valid !== 1'b1 || bus5.out_result !== 16'h4444 || bus5.out_sel !== 3'd4) begin
      errors++;
      $display("FAIL n5_sel4 out: got v=%b %h ch%0d expected v=1 4444 ch4", bus5.out_valid, bus5.out_result, bus5.out_sel);
    end
    $display("txn n5 sel=4 -> %h ch%0d", bus5.out_result, bus5.out_sel);
    bus5.sel = 3'd7;
    #1;
    checks++;
    if (bus5.in_ready !== 5'b00000) begin
      errors++;
      $display("FAIL n5_sel7 in_ready: got %b expected 00000", bus5.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus5.out_valid !== 1'b0 || bus5.out_result !== 16'h4444 || bus5.out_sel !== 3'd4) begin
      errors++;
      $display("FAIL n5_sel7 out: got v=%b %h ch%0d expected v=0 4444 ch4", bus5.out_valid, bus5.out_result, bus5.out_sel);
    end
    $display("txn n5 sel=7 -> out_valid=%0d", bus5.out_valid);
    // Round-robin wrap from the top channel back to 0
    bus5.mode     = 1'b1;
    bus5.in_valid = 5'b10000;
    #1;
    checks++;
    if (bus5.in_ready !== 5'b10000) begin
      errors++;
      $display("FAIL n5_rr4 in_ready: got %b expected 10000", bus5.in_ready);
    end
    @(posedge clk);
    #1;
    bus5.in_valid = 5'b11111;
    #1;
    checks++;
    if (bus5.in_ready !== 5'b00001) begin
      errors++;
      $display("FAIL n5_wrap in_ready: got %b expected 00001", bus5.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus5.out_sel !== 3'd0 || bus5.out_result !== 16'h0000 || bus5.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL n5_wrap out: got v=%b %h ch%0d expected v=1 0000 ch0", bus5.out_valid, bus5.out_result, bus5.out_sel);
    end
    $display("txn n5 wrap -> ch%0d", bus5.out_sel);
    bus5.in_valid = 5'b00000;
  endtask

  task automatic test_wrap3();
    do_reset(1);
    bus3.mode      = 1'b1;
    bus3.sel       = 2'd0;
    bus3.in_data   = {16'h0C02, 16'h0C01, 16'h0C00};
    bus3.out_ready = 1'b1;
    bus3.in_valid  = 3'b010;
    #1;
    checks++;
    if (bus3.in_ready !== 3'b010) begin
      errors++;
      $display("FAIL n3_ch1 in_ready: got %b expected 010", bus3.in_ready);
    end
    @(posedge clk);
    #1;
    $display("txn n3 grant ch%0d", bus3.out_sel);
    bus3.in_valid = 3'b001;
    #1;
    checks++;
    if (bus3.in_ready !== 3'b001) begin
      errors++;
      $display("FAIL n3_wrap in_ready: got %b expected 001", bus3.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus3.out_sel !== 2'd0 || bus3.out_result !== 16'h0C00) begin
      errors++;
      $display("FAIL n3_wrap out: got %h ch%0d expected 0c00 ch0", bus3.out_result, bus3.out_sel);
    end
    $display("txn n3 grant ch%0d", bus3.out_sel);
    // Pointer should now sit at channel 1
    bus3.in_valid = 3'b111;
    #1;
    checks++;
    if (bus3.in_ready !== 3'b010) begin
      errors++;
      $display("FAIL n3_ptr1 in_ready: got %b expected 010", bus3.in_ready);
    end
    @(posedge clk);
    #1;
    $display("txn n3 grant ch%0d", bus3.out_sel);
    bus3.in_valid = 3'b000;
  endtask

  initial begin
    reset          = 1'b1;
    bus5.in_data   = '0;
    bus5.in_valid  = '0;
    bus5.mode      = 1'b0;
    bus5.sel       = '0;
    bus5.out_ready = 1'b1;
    bus3.in_data   = '0;
    bus3.in_valid  = '0;
    bus3.mode      = 1'b0;
    bus3.sel       = '0;
    bus3.out_ready = 1'b1;
    test_reset();
    test_fixed();
    test_rr_fair();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_sel_oob();
    test_wrap3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
